// File: rtl/vend_credit_fsm.sv
// Vending credit controller. It takes filtered coin and button levels and
// turns each rising edge into a single event. It accumulates credit, vends
// when the credit covers PRICE, and returns change or a refund. All outputs
// are registered, so a response appears on the clock after the event.
// The parameters must satisfy PRICE <= MAX_CREDIT <= 255.
module vend_credit_fsm #(
   parameter int unsigned PRICE      = 15,
   parameter int unsigned COIN_A     = 5,
   parameter int unsigned COIN_B     = 10,
   parameter int unsigned COIN_C     = 25,
   parameter int unsigned MAX_CREDIT = 95
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       coin_a,
   input  logic       coin_b,
   input  logic       coin_c,
   input  logic       select,
   input  logic       cancel,
   output logic [7:0] credit,
   output logic       dispense,
   output logic       change_valid,
   output logic [7:0] change_value,
   output logic       coin_reject,
   output logic       short_credit
);

   typedef enum logic [1:0] {IDLE, COLLECT, VEND, REFUND} state_t;

   state_t     state, state_next;
   logic [4:0] prev;                 // {cancel, select, coin_c, coin_b, coin_a}
   logic [7:0] credit_next;
   logic       dispense_next;
   logic       change_valid_next;
   logic [7:0] change_value_next;
   logic       coin_reject_next;
   logic       short_credit_next;

   logic       ev_a, ev_b, ev_c, ev_sel, ev_cancel, any_coin, coin_fits;
   logic [8:0] coin_sum, credit_sum;

   // Rising-edge events; a level held high produces exactly one event.
   assign ev_a      = coin_a & ~prev[0];
   assign ev_b      = coin_b & ~prev[1];
   assign ev_c      = coin_c & ~prev[2];
   assign ev_sel    = select & ~prev[3];
   assign ev_cancel = cancel & ~prev[4];
   assign any_coin  = ev_a | ev_b | ev_c;

   // Coins arriving together are summed in 9 bits so the ceiling compare
   // cannot be fooled by an 8-bit wrap-around.
   assign coin_sum   = (ev_a ? 9'(COIN_A) : 9'd0)
                     + (ev_b ? 9'(COIN_B) : 9'd0)
                     + (ev_c ? 9'(COIN_C) : 9'd0);
   assign credit_sum = {1'b0, credit} + coin_sum;
   assign coin_fits  = (credit_sum <= 9'(MAX_CREDIT));

   // Edge history, state and all registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prev         <= '0;
         state        <= IDLE;
         credit       <= '0;
         dispense     <= 1'b0;
         change_valid <= 1'b0;
         change_value <= '0;
         coin_reject  <= 1'b0;
         short_credit <= 1'b0;
      end else begin
         prev         <= {cancel, select, coin_c, coin_b, coin_a};
         state        <= state_next;
         credit       <= credit_next;
         dispense     <= dispense_next;
         change_valid <= change_valid_next;
         change_value <= change_value_next;
         coin_reject  <= coin_reject_next;
         short_credit <= short_credit_next;
      end
   end

   // Next state and next outputs; pulses default low every cycle.
   always_comb begin
      state_next        = state;
      credit_next       = credit;
      dispense_next     = 1'b0;
      change_valid_next = 1'b0;
      change_value_next = '0;
      coin_reject_next  = 1'b0;
      short_credit_next = 1'b0;
      case (state)
         IDLE: begin
            // Credit is zero here, so any select is short.
            if (ev_sel)
               short_credit_next = 1'b1;
            if (any_coin) begin
               if (coin_fits) begin
                  credit_next = credit_sum[7:0];
                  state_next  = COLLECT;
               end else begin
                  coin_reject_next = 1'b1;
               end
            end
         end
         COLLECT: begin
            if (ev_cancel) begin
               state_next       = REFUND;
               coin_reject_next = any_coin;
            end else if (ev_sel && (credit >= 8'(PRICE))) begin
               state_next       = VEND;
               coin_reject_next = any_coin;
            end else begin
               if (ev_sel)
                  short_credit_next = 1'b1;
               if (any_coin) begin
                  if (coin_fits)
                     credit_next = credit_sum[7:0];
                  else
                     coin_reject_next = 1'b1;
               end
            end
         end
         VEND: begin
            dispense_next    = 1'b1;
            credit_next      = credit - 8'(PRICE);
            state_next       = (credit != 8'(PRICE)) ? REFUND : IDLE;
            coin_reject_next = any_coin;
         end
         REFUND: begin
            change_valid_next = 1'b1;
            change_value_next = credit;
            credit_next       = '0;
            state_next        = IDLE;
            coin_reject_next  = any_coin;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule
